chart_sequencer: RTL and testbench
==================================

CHART_SEQUENCER -- requirements
Module: chart_sequencer

Interface
REQ-001 Parameter CHART_LEN, default 274; number of chart rows, addresses 0..CHART_LEN-1.
REQ-002 Parameter BEAT_DIV, default 6250000; clk cycles per chart row, minimum 4.
REQ-003 Parameter ADDR_W, default 13; chart ROM address width.
REQ-004 clk  input  1  sole clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin playback from row 0.
REQ-007 pause  input  1  level; freezes playback while high.
REQ-008 rom_addr  output  ADDR_W  address to chart ROM.
REQ-009 rom_data  input  4  chart ROM row; registered ROM, valid one cycle after rom_addr is sampled.
REQ-010 spawn_valid  output  1  lane-spawn request to the note renderer.
REQ-011 spawn_lanes  output  4  lane bitmask, bit3 = leftmost lane.
REQ-012 spawn_ready  input  1  renderer accepts spawn when high together with spawn_valid.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  high in DONE.
REQ-015 overrun  output  1  sticky; a row's spawn was still pending at its beat boundary.

Function
REQ-016 FSM states: IDLE, FETCH, LATCH, ISSUE, HOLD, DONE.
REQ-017 IDLE: start=1 -> rom_addr=0, beat counter=BEAT_DIV-1, overrun cleared, go FETCH.
REQ-018 FETCH: one cycle; ROM samples rom_addr; go LATCH.
REQ-019 LATCH: capture rom_data; nonzero -> spawn_lanes=rom_data, spawn_valid=1, go ISSUE; zero -> go HOLD, no spawn.
REQ-020 ISSUE: spawn_valid and spawn_lanes held stable until spawn_valid&spawn_ready; handshake cycle drops spawn_valid next cycle, go HOLD.
REQ-021 Beat counter decrements once per cycle in FETCH, LATCH, ISSUE, HOLD; reloads BEAT_DIV-1 on every row advance.
REQ-022 HOLD: counter==0 -> advance row; rom_addr+1 and FETCH if rom_addr<CHART_LEN-1, else DONE.
REQ-023 Counter reaching 0 in ISSUE: overrun set; counter holds at 0; row advances in the cycle after the handshake.
REQ-024 Row period is exactly BEAT_DIV cycles when no overrun and no pause.
REQ-025 pause=1: state, counter, rom_addr frozen; spawn_valid and spawn_lanes held; a handshake presented during pause still completes, and ISSUE then waits in HOLD.
REQ-026 start ignored when busy=1; start in DONE behaves as in IDLE.
REQ-027 start and pause high together in IDLE: start taken, FSM enters FETCH, then freezes.
REQ-028 spawn_lanes keeps last issued value when spawn_valid=0.

Reset
REQ-029 reset=1 forces IDLE immediately, independent of clk.
REQ-030 Reset values: rom_addr=0, spawn_valid=0, spawn_lanes=0, busy=0, done=0, overrun=0, beat counter=0.
REQ-031 Reset mid-row drops spawn_valid with no handshake; the row is discarded.

Configuration
REQ-032 Macro CHART_LOOP_EN defined: at the last row's beat boundary the FSM goes to FETCH with rom_addr=0 instead of DONE; done never asserts; overrun not cleared on wrap.
REQ-033 Macro CHART_LOOP_EN absent: playback ends in DONE as in REQ-022; no loop logic synthesised.

Verification (BEAT_DIV=8, CHART_LEN=274, chart rows 0-3=0000, 4=1000, 5=0100)
REQ-034 reset release, start at cycle 0, spawn_ready=1 -> no spawn for rows 0-3; first spawn_valid with lanes 1000 at cycle 34 (row 4 start 32 + 2); lanes 0100 at cycle 42.
REQ-035 spawn_ready=0 for 20 cycles at row 4 -> spawn_valid/lanes 1000 held stable, overrun=1, rom_addr stays 4 until handshake, then 5.
REQ-036 pause high 15 cycles in HOLD of row 5 -> rom_addr=5 extended by exactly 15 cycles; no spurious spawn.
REQ-037 run to end without CHART_LOOP_EN -> done=1, busy=0, rom_addr=273 after 274*8 cycles; start again -> rom_addr=0, done=0.
REQ-038 with CHART_LOOP_EN, run past row 273 -> rom_addr wraps to 0, busy stays 1, done stays 0.
REQ-039 reset asserted mid-ISSUE, asynchronous to clk -> spawn_valid=0 and busy=0 before the next posedge; start afterwards replays from row 0.

Source files
------------

// File: rtl/chart_sequencer.sv
// chart_sequencer: plays a chart ROM one row per beat and hands non-empty rows to the note renderer.
// Optional macro CHART_LOOP_EN: wrap to row 0 after the last row instead of stopping in DONE.
module chart_sequencer #(
  parameter int unsigned CHART_LEN = 274,
  parameter int unsigned BEAT_DIV  = 6250000,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              spawn_valid,
  output logic [3:0]        spawn_lanes,
  input  logic              spawn_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned        CntW      = $clog2(BEAT_DIV);
  localparam logic [CntW-1:0]    CntReload = CntW'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0]  LastAddr  = ADDR_W'(CHART_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StHold,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [3:0]        lanes_q, lanes_d;
  logic              overrun_q, overrun_d;

  logic              cnt_zero;
  logic [CntW-1:0]   cnt_dec;
  logic              handshake;

  assign cnt_zero  = (cnt_q == '0);
  assign cnt_dec   = cnt_q - CntW'(1);
  assign handshake = valid_q & spawn_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      lanes_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      lanes_q   <= lanes_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    lanes_d   = lanes_q;
    overrun_d = overrun_q;

    case (state_q)
      // Start is honoured even while paused; the freeze applies from FETCH onwards.
      StIdle, StDone: begin
        if (start) begin
          state_d   = StFetch;
          addr_d    = '0;
          cnt_d     = CntReload;
          overrun_d = 1'b0;
        end
      end

      StFetch: begin
        if (!pause) begin
          state_d = StLatch;
          cnt_d   = cnt_dec;
        end
      end

      StLatch: begin
        if (!pause) begin
          cnt_d = cnt_dec;
          if (rom_data != 4'b0000) begin
            lanes_d = rom_data;
            valid_d = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StHold;
          end
        end
      end

      StIssue: begin
        // A handshake completes even while paused; the beat counter does not move then.
        if (handshake) begin
          valid_d = 1'b0;
          state_d = StHold;
        end
        if (!pause) begin
          if (cnt_zero) begin
            overrun_d = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end
      end

      StHold: begin
        if (!pause) begin
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end else if (addr_q < LastAddr) begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = CntReload;
            state_d = StFetch;
          end else begin
`ifdef CHART_LOOP_EN
            addr_d  = '0;
            cnt_d   = CntReload;
            state_d = StFetch;
`else
            state_d = StDone;
`endif
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rom_addr    = addr_q;
  assign spawn_valid = valid_q;
  assign spawn_lanes = lanes_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: row-timeline reference model compared every cycle, plus directed
// literal checks of spawn timing, overrun, pause stretch, end of chart and asynchronous reset.
module tb_chart_sequencer;

  localparam int unsigned LEN = 274;
  localparam int unsigned BD  = 8;
  localparam int unsigned AW  = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          spawn_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data = 4'b0000;
  logic          spawn_valid;
  logic [3:0]    spawn_lanes;
  logic          busy;
  logic          done;
  logic          overrun;

  logic [3:0]    chart [LEN];

  int checks = 0;
  int errors = 0;

  chart_sequencer #(
    .CHART_LEN(LEN),
    .BEAT_DIV (BD),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Registered chart ROM
  always @(posedge clk) rom_data <= chart[rom_addr];

  // Reference model: a row is an interval of active (unpaused) cycles counted by m_el from 0.
  // Row data is seen at el 1; a spawn is pending from then until handshake; the row ends once
  // at least BD active cycles have elapsed with nothing pending.
  int       m_row;
  int       m_el;
  bit       m_act;
  bit       m_fin;
  bit       m_pend;
  bit       m_ovr;
  logic [3:0] m_lanes;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_row <= 0; m_el <= 0; m_act <= 1'b0; m_fin <= 1'b0;
      m_pend <= 1'b0; m_ovr <= 1'b0; m_lanes <= 4'b0000;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1; m_fin <= 1'b0; m_row <= 0; m_el <= 0; m_ovr <= 1'b0;
      end
    end else if (pause) begin
      if (m_pend && spawn_ready) m_pend <= 1'b0;
    end else if (!m_pend && m_el >= int'(BD) - 1) begin
      m_el <= 0;
      if (m_row < int'(LEN) - 1) begin
        m_row <= m_row + 1;
      end else begin
`ifdef CHART_LOOP_EN
        m_row <= 0;
`else
        m_act <= 1'b0;
        m_fin <= 1'b1;
`endif
      end
    end else begin
      if (m_pend) begin
        if (m_el >= int'(BD) - 1) m_ovr <= 1'b1;
        if (spawn_ready) m_pend <= 1'b0;
      end
      if (m_el == 1 && chart[m_row] != 4'b0000) begin
        m_pend  <= 1'b1;
        m_lanes <= chart[m_row];
      end
      m_el <= m_el + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      chk("model rom_addr", 32'(rom_addr), 32'(m_row));
      chk("model spawn_valid", 32'(spawn_valid), 32'(m_pend));
      chk("model spawn_lanes", 32'(spawn_lanes), 32'(m_lanes));
      chk("model busy", 32'(busy), 32'(m_act));
      chk("model done", 32'(done), 32'(m_fin));
      chk("model overrun", 32'(overrun), 32'(m_ovr));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int first_c, second_c, n5, n5v, bad, burst, c;
    logic [3:0] first_l, second_l;
    bit seen;

    for (int i = 0; i < int'(LEN); i++) begin
      chart[i] = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    end
    for (int i = 0; i < 4; i++) chart[i] = 4'b0000;
    chart[4] = 4'b1000;
    chart[5] = 4'b0100;
    chart[7] = 4'b0011;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset spawn_valid", 32'(spawn_valid), 0);
    chk("reset spawn_lanes", 32'(spawn_lanes), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick();

    // Run A: spawn timing, then a 15-cycle pause in the hold of row 5, then the full chart
    pulse_start();
    chk("start busy", 32'(busy), 1);
    chk("start rom_addr", 32'(rom_addr), 0);
    first_c = -1; second_c = -1; n5 = 0; n5v = 0;
    first_l = 4'b0000; second_l = 4'b0000;
    for (c = 0; c <= 70; c++) begin
      if (spawn_valid) begin
        if (first_c < 0) begin
          first_c = c; first_l = spawn_lanes;
        end else if (second_c < 0) begin
          second_c = c; second_l = spawn_lanes;
        end
      end
      if (rom_addr == 5) begin
        n5++;
        if (spawn_valid) n5v++;
      end
      if (c == 43) pause = 1'b1;
      if (c == 58) pause = 1'b0;
      tick();
    end
    chk("first spawn cycle", 32'(first_c), 34);
    chk("first spawn lanes", 32'(first_l), 32'b1000);
    chk("second spawn cycle", 32'(second_c), 42);
    chk("second spawn lanes", 32'(second_l), 32'b0100);
    chk("row5 stretched length", 32'(n5), 23);
    chk("row5 spawn count", 32'(n5v), 1);
    while (c < int'(LEN * BD) + 14) begin
      tick();
      c++;
    end
    chk("last cycle busy", 32'(busy), 1);
    tick();
    c++;
`ifdef CHART_LOOP_EN
    chk("wrap rom_addr", 32'(rom_addr), 0);
    chk("wrap busy", 32'(busy), 1);
    chk("wrap done", 32'(done), 0);
`else
    chk("end rom_addr", 32'(rom_addr), LEN - 1);
    chk("end busy", 32'(busy), 0);
    chk("end done", 32'(done), 1);
`endif
    chk("end overrun", 32'(overrun), 0);
    pulse_start();
    chk("restart rom_addr", 32'(rom_addr), 0);
    chk("restart done", 32'(done), 0);
    chk("restart busy", 32'(busy), 1);

    // Run B: renderer stalls on row 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spawn_ready = 1'b0;
    pulse_start();
    bad = 0;
    for (c = 0; c <= 60; c++) begin
      if (c >= 34 && c <= 53 && !(spawn_valid === 1'b1 && spawn_lanes === 4'b1000)) bad++;
      if (c == 53) begin
        chk("stall overrun", 32'(overrun), 1);
        chk("stall rom_addr", 32'(rom_addr), 4);
        spawn_ready = 1'b1;
      end
      if (c == 54) begin
        chk("post-handshake valid", 32'(spawn_valid), 0);
        chk("post-handshake rom_addr", 32'(rom_addr), 4);
      end
      if (c == 55) chk("advance rom_addr", 32'(rom_addr), 5);
      tick();
    end
    chk("stall stable cycles bad", 32'(bad), 0);

    // Asynchronous reset while a spawn is pending
    spawn_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (spawn_valid) seen = 1'b1;
      else tick();
    end
    chk("pending spawn seen", 32'(seen), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset valid", 32'(spawn_valid), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset rom_addr", 32'(rom_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    spawn_ready = 1'b1;
    tick();
    pulse_start();
    chk("replay rom_addr", 32'(rom_addr), 0);
    chk("replay busy", 32'(busy), 1);

    // Randomised traffic: sporadic starts, pauses and renderer stalls
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 9) == 0);
      if (burst > 0) begin
        burst--;
        spawn_ready = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        burst = $urandom_range(5, 14);
        spawn_ready = 1'b0;
      end else begin
        spawn_ready = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    start = 1'b0;
    pause = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
